core_task_receiver: RTL and testbench
=====================================

# core_task_receiver

Core-side receiver for the scheduler's task-dispatch protocol; one instance sits in front of every core. It detects a dispatch that selects its core and latches the core's r0 init value. It then pulls the task's instruction frames off the shared 16-bit message bus into a local instruction buffer, starts the execution unit, and returns the per-core `core_ready` completion pulse that clears the core's bit in the scheduler's exec mask.

## Interface
- `CORE_ID`, 0: index of this core in the dispatch/init vectors
- `CORE_NUM`, 16: width of the dispatch masks
- `INSTR_SIZE`, 16: message/instruction word width
- `FRAME_SIZE`, 16: words per frame
- `IMEM_DEPTH`, 1024: instruction buffer words; must be ≥ 63·FRAME_SIZE

Ports:
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `dispatch_vld` in 1: scheduler accepted a task this cycle (1-cycle pulse)
- `dispatch_mask` in CORE_NUM: exec mask of the dispatched task
- `dispatch_if_num` in 6: instruction frames to follow
- `init_r0_vect` in CORE_NUM: cores whose r0 is initialised
- `r0_data` in INSTR_SIZE: r0 value for this core
- `mess_in` in INSTR_SIZE: scheduler message word, registered one cycle after each `core_reading` cycle
- `core_reading` out 1: request one word per cycle; OR-ed across cores at top level
- `core_ready` out 1: task complete, 1-cycle pulse
- `exec_start` out 1: program loaded, 1-cycle pulse
- `exec_r0` out INSTR_SIZE: latched r0 for the execution unit
- `exec_done` in 1: execution unit finished
- `imem_raddr` in 10: instruction fetch address
- `imem_rdata` out INSTR_SIZE: fetched word, 1-cycle latency
- `protocol_err` out 1: sticky, set on a dispatch selecting this core while busy

## Operation
- States: IDLE, LOAD, DRAIN, RUN, DONE.
- IDLE:
  - `dispatch_vld && dispatch_mask[CORE_ID]` latches the load length N = if_num·FRAME_SIZE.
  - It latches `exec_r0 = init_r0_vect[CORE_ID] ? r0_data : 0`.
  - It clears `req_cnt` and `wr_ptr`.
  - Next state is LOAD, or DONE if if_num == 0.
  - A dispatch without this core's bit is ignored.
- LOAD:
  - `core_reading` = 1 and `req_cnt` increments each cycle.
  - After N requests, go to DRAIN.
- Capture: `rd_q` is `core_reading` delayed one cycle. While `rd_q`, write `mess_in` to `imem[wr_ptr]` and increment `wr_ptr`.
- DRAIN: `core_reading` = 0. Capture the final word, then go to RUN.
- RUN:
  - `exec_start` is high in the first RUN cycle only.
  - `exec_done` (accepted in any RUN cycle, including the first) moves to DONE.
- DONE: `core_reading` = 0, `core_ready` = 1 for exactly this cycle, next state IDLE.
- A dispatch selecting this core while not IDLE is ignored and sets `protocol_err`; the current task is unaffected.
- `exec_done` outside RUN is ignored.
- Widths:
  - `req_cnt` and `wr_ptr` are 10-bit, with no wrap for legal if_num (max 1008 words).
  - `imem_raddr` beyond `wr_ptr` returns stale data; this is not an error.

## Timing
- Reset values: state IDLE; `core_reading`, `core_ready`, `exec_start`, `protocol_err` = 0; `exec_r0`, `imem_rdata` = 0; counters 0. Buffer contents are undefined.
- Reset mid-task: at the next edge the block is IDLE with `core_reading` = 0. Words still in flight are discarded.
- Dispatch sampled at edge E:
  - `core_reading` is high in cycles E..E+N−1.
  - Word k is on `mess_in` in cycle E+1+k and written at edge E+2+k.
  - DRAIN is cycle E+N.
  - `exec_start` is high in cycle E+N+1.
- `exec_done` sampled at edge D puts `core_ready` high in cycle D; the block is IDLE from D+1.
- if_num == 0: `core_ready` is high in cycle E, with no `exec_start` and no `core_reading`.
- `imem_rdata` is registered: address sampled at edge T gives data in cycle T.

## Structure
- Shared package `gpu_pkg`: FRAME_SIZE, INSTR_SIZE, IFNUM width (6), fence encodings (ACQ = 1, REL = 2), header field masks, receiver state enum.
- One sub-module: `ibuf_ram`, a synchronous 1-write/1-read RAM of IMEM_DEPTH×INSTR_SIZE with registered read.
- The FSM, counters, and r0 latch live in `core_task_receiver`.

## Test plan
- Reset then idle for 20 cycles -> all outputs 0, state IDLE.
- Dispatch CORE_ID = 3, mask 0x0008, if_num = 1, init_r0_vect 0x0008, `r0_data` 0xBEEF; `mess_in` = 0x1000+k -> `core_reading` high for 16 cycles, imem[0..15] = 0x1000..0x100F, `exec_start` at E+17, `exec_r0` = 0xBEEF; `exec_done` at D -> `core_ready` pulse in cycle D.
- Dispatch with mask 0x0004 (bit 3 clear) -> no `core_reading`, state stays IDLE; with if_num = 0 and bit set -> `core_ready` pulse in cycle E, no `exec_start`.
- Second dispatch with bit 3 set at request 5 of LOAD -> `protocol_err` = 1 and stays 1; load completes with all 16 words correct.
- Reset asserted at request 5 -> `core_reading` 0 next cycle; a re-dispatch with if_num = 2 loads 32 words starting at address 0.
- if_num = 63 -> 1008 requests, last word at imem[1007], `exec_start` at E+1009; a readback through `imem_raddr` matches all words.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared constants and types for the GPU task-dispatch path.
//   FRAME_SIZE / INSTR_SIZE : frame length in words and message word width
//   IFNUM_W                 : width of the instruction-frame count field
//   FENCE_ACQ / FENCE_REL   : fence encodings carried in task headers
//   HDR_*_MASK              : task-header field masks on the message bus
//   rx_state_t              : core task receiver state encoding
package gpu_pkg;

  localparam int FRAME_SIZE = 16;
  localparam int INSTR_SIZE = 16;
  localparam int IFNUM_W    = 6;

  localparam logic [1:0] FENCE_ACQ = 2'd1;
  localparam logic [1:0] FENCE_REL = 2'd2;

  localparam logic [15:0] HDR_OPCODE_MASK = 16'hF000;
  localparam logic [15:0] HDR_FENCE_MASK  = 16'h0C00;
  localparam logic [15:0] HDR_IFNUM_MASK  = 16'h03F0;
  localparam logic [15:0] HDR_CORE_MASK   = 16'h000F;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_LOAD  = 3'd1,
    RX_DRAIN = 3'd2,
    RX_RUN   = 3'd3,
    RX_DONE  = 3'd4
  } rx_state_t;

  // Number of instruction words that follow a dispatch of if_num frames.
  function automatic logic [9:0] load_words(input logic [IFNUM_W-1:0] if_num,
                                            input int frame_size);
    return 10'(if_num) * 10'(frame_size);
  endfunction

endpackage

// File: rtl/ibuf_ram.sv
// ibuf_ram: per-core instruction buffer, 1 write port / 1 read port.
//   clk, reset : clock; reset clears only the read-data register
//   we, waddr, wdata : synchronous write
//   raddr, rdata     : registered read, address sampled at edge T gives
//                      data in cycle T
module ibuf_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/core_task_receiver.sv
// core_task_receiver: per-core front end of the task-dispatch protocol.
// Detects a dispatch selecting CORE_ID, latches r0, pulls N = if_num*FRAME_SIZE
// instruction words off the shared message bus into ibuf_ram, starts the
// execution unit and returns a one-cycle core_ready when the task completes.
//   dispatch_vld/mask/if_num, init_r0_vect, r0_data : scheduler dispatch
//   mess_in / core_reading : message bus word / per-cycle word request
//   exec_start, exec_r0, exec_done : execution unit interface
//   imem_raddr / imem_rdata : instruction fetch port (1-cycle latency)
//   core_ready : completion pulse; protocol_err : sticky busy-dispatch flag
//   state_dbg : current FSM state
//
// Bus handshake: core_reading is a request with no backpressure. Every cycle
// it is high, the scheduler owes exactly one word, presented on mess_in in
// the following cycle. There is no ready/valid on the response side: rd_q
// (core_reading delayed one cycle) marks the cycles in which mess_in is valid.
module core_task_receiver
  import gpu_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int CORE_NUM   = 16,
  parameter int INSTR_SIZE = 16,
  parameter int FRAME_SIZE = 16,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_vld,
  input  logic [CORE_NUM-1:0]   dispatch_mask,
  input  logic [5:0]            dispatch_if_num,
  input  logic [CORE_NUM-1:0]   init_r0_vect,
  input  logic [INSTR_SIZE-1:0] r0_data,
  input  logic [INSTR_SIZE-1:0] mess_in,
  output logic                  core_reading,
  output logic                  core_ready,
  output logic                  exec_start,
  output logic [INSTR_SIZE-1:0] exec_r0,
  input  logic                  exec_done,
  input  logic [9:0]            imem_raddr,
  output logic [INSTR_SIZE-1:0] imem_rdata,
  output logic                  protocol_err,
  output rx_state_t             state_dbg
);

  rx_state_t   state, state_nxt;
  logic [9:0]  req_cnt;
  logic [9:0]  wr_ptr;
  logic [9:0]  n_words;
  logic        rd_q;
  logic        exec_start_q;
  logic        sel_dispatch;
  logic        accept;

  assign sel_dispatch = dispatch_vld && dispatch_mask[CORE_ID];
  assign accept       = sel_dispatch && (state == RX_IDLE);

  always_comb begin
    state_nxt    = state;
    core_reading = 1'b0;
    core_ready   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (sel_dispatch)
          state_nxt = (dispatch_if_num == 6'd0) ? RX_DONE : RX_LOAD;
      end
      RX_LOAD: begin
        core_reading = 1'b1;
        // req_cnt counts requests already issued; this cycle issues the last.
        if (req_cnt == n_words - 10'd1) state_nxt = RX_DRAIN;
      end
      RX_DRAIN: state_nxt = RX_RUN;   // final word lands at the end of DRAIN
      RX_RUN: begin
        if (exec_done) state_nxt = RX_DONE;
      end
      RX_DONE: begin
        core_ready = 1'b1;
        state_nxt  = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RX_IDLE;
      req_cnt      <= '0;
      wr_ptr       <= '0;
      n_words      <= '0;
      rd_q         <= 1'b0;
      exec_start_q <= 1'b0;
      exec_r0      <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_q         <= core_reading;
      // DRAIN always hands over to RUN, so this marks the first RUN cycle.
      exec_start_q <= (state == RX_DRAIN);

      if (accept) begin
        n_words <= load_words(dispatch_if_num, FRAME_SIZE);
        exec_r0 <= init_r0_vect[CORE_ID] ? r0_data : '0;
        req_cnt <= '0;
      end else if (state == RX_LOAD) begin
        req_cnt <= req_cnt + 10'd1;
      end

      if (accept)    wr_ptr <= '0;
      else if (rd_q) wr_ptr <= wr_ptr + 10'd1;

      if (sel_dispatch && (state != RX_IDLE)) protocol_err <= 1'b1;
    end
  end

  assign exec_start = exec_start_q;
  assign state_dbg  = state;

  ibuf_ram #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (INSTR_SIZE),
    .AW    (10)
  ) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .we    (rd_q),
    .waddr (wr_ptr),
    .wdata (mess_in),
    .raddr (imem_raddr),
    .rdata (imem_rdata)
  );

endmodule

// File: tb/tb_core_task_receiver.sv
// Testbench for core_task_receiver (CORE_ID = 3).
module tb_core_task_receiver;
  import gpu_pkg::*;

  localparam int CID = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        dispatch_vld;
  logic [15:0] dispatch_mask;
  logic [5:0]  dispatch_if_num;
  logic [15:0] init_r0_vect;
  logic [15:0] r0_data;
  logic [15:0] mess_in;
  logic        core_reading;
  logic        core_ready;
  logic        exec_start;
  logic [15:0] exec_r0;
  logic        exec_done;
  logic [9:0]  imem_raddr;
  logic [15:0] imem_rdata;
  logic        protocol_err;
  rx_state_t   state_dbg;

  core_task_receiver #(
    .CORE_ID    (CID),
    .CORE_NUM   (16),
    .INSTR_SIZE (16),
    .FRAME_SIZE (16),
    .IMEM_DEPTH (1024)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .dispatch_vld    (dispatch_vld),
    .dispatch_mask   (dispatch_mask),
    .dispatch_if_num (dispatch_if_num),
    .init_r0_vect    (init_r0_vect),
    .r0_data         (r0_data),
    .mess_in         (mess_in),
    .core_reading    (core_reading),
    .core_ready      (core_ready),
    .exec_start      (exec_start),
    .exec_r0         (exec_r0),
    .exec_done       (exec_done),
    .imem_raddr      (imem_raddr),
    .imem_rdata      (imem_rdata),
    .protocol_err    (protocol_err),
    .state_dbg       (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scheduler message-bus model ----------------
  // One word owed for every cycle core_reading was high, one cycle later.
  logic [15:0] src_words [1024];
  int          src_idx = 0;
  logic        rd_seen;

  initial begin
    mess_in = '0;
    forever begin
      @(negedge clk);
      rd_seen = core_reading;
      @(posedge clk);
      #1;
      if (rd_seen) begin
        mess_in = src_words[src_idx];
        src_idx++;
      end else begin
        mess_in = 16'($urandom);
      end
    end
  end

  task automatic fill_src(input bit incr);
    for (int i = 0; i < 1024; i++)
      src_words[i] = incr ? 16'(16'h1000 + i) : 16'($urandom);
  endtask

  // Read back the first n buffer words and compare against the expected queue.
  task automatic check_mem(input int n, input string tag);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(src_words[i]);
    for (int a = 0; a < n; a++) begin
      imem_raddr = 10'(a);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s:imem[%0d]", tag, a), 32'(imem_rdata), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one dispatch and its full lifetime ----------------
  task automatic run_task(input int if_num, input logic [15:0] mask,
                          input logic [15:0] init_vect, input logic [15:0] r0,
                          input int delay, input int redisp_at,
                          input int exp_n, input bit exp_sel,
                          input logic [15:0] exp_r0, input string tag);
    int rd_cnt, rd_first, st_cnt, st_cyc, rdy_cnt, rdy_cyc, busy_cnt, lim;
    rd_cnt = 0; rd_first = -1; st_cnt = 0; st_cyc = -1;
    rdy_cnt = 0; rdy_cyc = -1; busy_cnt = 0;
    src_idx = 0;
    dispatch_vld    = 1'b1;
    dispatch_mask   = mask;
    dispatch_if_num = 6'(if_num);
    init_r0_vect    = init_vect;
    r0_data         = r0;
    @(posedge clk);   // edge E
    #1;
    dispatch_vld = 1'b0;
    r0_data      = 16'($urandom);
    init_r0_vect = 16'($urandom);
    lim = exp_n + delay + 8;
    for (int c = 0; c < lim; c++) begin
      exec_done = exp_sel && (c == exp_n + 1 + delay);
      if (redisp_at >= 0 && c == redisp_at) begin
        dispatch_vld    = 1'b1;
        dispatch_mask   = 16'h0008;
        dispatch_if_num = 6'd5;
      end else begin
        dispatch_vld = 1'b0;
      end
      @(negedge clk);
      if (core_reading) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
      end
      if (exec_start) begin
        st_cnt++;
        if (st_cyc < 0) st_cyc = c;
      end
      if (core_ready) begin
        rdy_cnt++;
        if (rdy_cyc < 0) rdy_cyc = c;
      end
      if (state_dbg != RX_IDLE) busy_cnt++;
      @(posedge clk);
      #1;
    end
    exec_done    = 1'b0;
    dispatch_vld = 1'b0;

    check({tag, ":reading_cycles"}, 32'(rd_cnt), 32'(exp_n));
    check({tag, ":exec_start_cnt"}, 32'(st_cnt), (exp_n > 0) ? 32'd1 : 32'd0);
    check({tag, ":core_ready_cnt"}, 32'(rdy_cnt), exp_sel ? 32'd1 : 32'd0);
    check({tag, ":busy_cycles"}, 32'(busy_cnt),
          !exp_sel ? 32'd0 : (exp_n == 0) ? 32'd1 : 32'(exp_n + 3 + delay));
    if (exp_n > 0) begin
      check({tag, ":first_reading"}, 32'(rd_first), 32'd0);
      check({tag, ":exec_start_cyc"}, 32'(st_cyc), 32'(exp_n + 1));
    end
    if (exp_sel) begin
      check({tag, ":core_ready_cyc"}, 32'(rdy_cyc),
            (exp_n == 0) ? 32'd0 : 32'(exp_n + 2 + delay));
      check({tag, ":exec_r0"}, 32'(exec_r0), 32'(exp_r0));
    end
    check({tag, ":end_state"}, 32'(state_dbg), 32'(RX_IDLE));
    if (exp_n > 0) check_mem(exp_n, tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          if_num;
    logic [15:0] mask;
    logic [15:0] init_vect;
    logic [15:0] r0;
    int          delay;
    int          redisp_at;
    bit          incr_pat;
    int          exp_n;
    bit          exp_sel;
    logic [15:0] exp_r0;
    bit          exp_perr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    dispatch_vld = 0; dispatch_mask = '0; dispatch_if_num = '0;
    init_r0_vect = '0; r0_data = '0; exec_done = 0; imem_raddr = '0;
    reset = 1'b1;

    tbl[0] = '{1, 16'h0008, 16'h0008, 16'hBEEF, 0, -1, 1'b1, 16,  1'b1, 16'hBEEF, 1'b0};
    tbl[1] = '{1, 16'h0004, 16'h0008, 16'h1234, 0, -1, 1'b0, 0,   1'b0, 16'h0000, 1'b0};
    tbl[2] = '{0, 16'h0008, 16'h0008, 16'h5555, 0, -1, 1'b0, 0,   1'b1, 16'h5555, 1'b0};
    tbl[3] = '{2, 16'hFFFF, 16'h0000, 16'hABCD, 3, -1, 1'b0, 32,  1'b1, 16'h0000, 1'b0};
    tbl[4] = '{1, 16'h0008, 16'h0008, 16'h7777, 2, 5,  1'b0, 16,  1'b1, 16'h7777, 1'b1};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset:imem_rdata", 32'(imem_rdata), 32'd0);
    check("reset:exec_r0", 32'(exec_r0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle:outputs", {28'd0, core_reading, core_ready, exec_start, protocol_err}, 32'd0);
    end
    check("idle:state", 32'(state_dbg), 32'(RX_IDLE));
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      fill_src(tbl[i].incr_pat);
      run_task(tbl[i].if_num, tbl[i].mask, tbl[i].init_vect, tbl[i].r0,
               tbl[i].delay, tbl[i].redisp_at, tbl[i].exp_n, tbl[i].exp_sel,
               tbl[i].exp_r0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d:protocol_err", i), 32'(protocol_err), 32'(tbl[i].exp_perr));
    end

    // Randomized dispatches against the reference rules.
    for (int t = 0; t < 8; t++) begin
      int          r_if, r_delay, r_n;
      logic [15:0] r_mask, r_init, r_r0, r_exp_r0;
      bit          r_sel;
      r_if    = $urandom_range(0, 4);
      r_mask  = 16'($urandom);
      r_init  = 16'($urandom);
      r_r0    = 16'($urandom);
      r_delay = $urandom_range(0, 5);
      r_sel    = r_mask[CID];
      r_n      = r_sel ? r_if * 16 : 0;
      r_exp_r0 = r_init[CID] ? r_r0 : 16'h0000;
      fill_src(1'b0);
      run_task(r_if, r_mask, r_init, r_r0, r_delay, -1, r_n, r_sel, r_exp_r0,
               $sformatf("rnd%0d", t));
    end
    check("sticky:protocol_err", 32'(protocol_err), 32'd1);

    // Reset in the middle of a load.
    fill_src(1'b0);
    src_idx = 0;
    dispatch_vld = 1'b1; dispatch_mask = 16'h0008; dispatch_if_num = 6'd1;
    init_r0_vect = 16'h0008; r0_data = 16'h4242;
    @(posedge clk);
    #1;
    dispatch_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset:reading_before", 32'(core_reading), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset:reading_after", 32'(core_reading), 32'd0);
    check("midreset:state", 32'(state_dbg), 32'(RX_IDLE));
    check("midreset:protocol_err", 32'(protocol_err), 32'd0);
    check("midreset:exec_r0", 32'(exec_r0), 32'd0);
    @(posedge clk);
    #1;
    fill_src(1'b0);
    run_task(2, 16'h0008, 16'h0000, 16'h9999, 1, -1, 32, 1'b1, 16'h0000, "redisp");

    // Maximum-length task.
    fill_src(1'b0);
    run_task(63, 16'h8008, 16'h0008, 16'hC0DE, 0, -1, 1008, 1'b1, 16'hC0DE, "max");
    check("final:protocol_err", 32'(protocol_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
